lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, 255, max ACCESS cycles without mem_ack_i before abort; 0 disables timeout.
REQ-002 clk_i  in  1  sole clock; all state changes on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 req_i  in  1  datapath load/store request, held until stall_o low.
REQ-005 wren_i  in  1  1 = store, 0 = load; sampled with req_i.
REQ-006 func3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-007 addr_i  in  32  byte address from ALU.
REQ-008 wdata_i  in  32  store data, rs2.
REQ-009 stall_o  out  1  datapath freeze.
REQ-010 done_o  out  1  one-cycle completion pulse.
REQ-011 rdata_o  out  32  extended load result, valid while done_o.
REQ-012 err_o  out  1  one-cycle fault pulse, coincident with done_o.
REQ-013 cause_o  out  2  01 misaligned, 10 illegal size, 11 timeout, 00 none.
REQ-014 mem_req_o  out  1  memory request, held until mem_ack_i.
REQ-015 mem_we_o  out  1  memory write enable.
REQ-016 mem_addr_o  out  32  word address, bits [1:0] = 00.
REQ-017 mem_be_o  out  4  byte-lane enables.
REQ-018 mem_wdata_o  out  32  lane-replicated store data.
REQ-019 mem_ack_i  in  1  memory completion; load data valid same cycle.
REQ-020 mem_rdata_i  in  32  memory read word.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; all mem_* outputs and rdata_o/cause_o registered.
REQ-022 IDLE, req_i=1, legal and aligned: capture wren/func3/addr/wdata, go ACCESS; mem_req_o high from the next cycle.
REQ-023 IDLE, req_i=1, fault: no memory access; go RESP with err, cause 01 (H not addr[0]=0, W not addr[1:0]=00) or 10 (store func3 not 000/001/010; load func3 011/110/111); illegal size takes priority over misaligned.
REQ-024 stall_o = (IDLE & req_i) | ACCESS; low in RESP so the datapath retires the instruction.
REQ-025 ACCESS: mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o stable until mem_ack_i; on ack capture data, mem_req_o low next cycle, go RESP.
REQ-026 mem_be_o: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; same mask for loads.
REQ-027 mem_wdata_o: B = byte replicated x4; H = halfword replicated x2; W = wdata_i; 0 for loads.
REQ-028 Load extraction: lane selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged; rdata_o = 0 for stores and faults.
REQ-029 Wait counter clears entering ACCESS, increments each ACCESS cycle without ack; reaching TIMEOUT: drop mem_req_o, go RESP, cause 11.
REQ-030 Ack in same cycle counter reaches TIMEOUT: ack wins, no error.
REQ-031 RESP lasts exactly one cycle: done_o=1, err_o per cause; req_i ignored; then IDLE.
REQ-032 mem_ack_i outside ACCESS ignored; back-to-back requests: new request accepted first IDLE cycle after RESP.

Reset
REQ-033 rst_ni low: immediately IDLE, counter 0, all outputs 0 (stall_o follows REQ-024 only after release); in-flight access abandoned, no done_o.
REQ-034 First request accepted on the first rising edge after rst_ni returns high.

Verification
REQ-035 LB addr 0x103, mem_rdata 0x80FF_FFFF, ack after 2 cycles -> be 1000, addr 0x100, rdata_o 0xFFFF_FF80, done_o one pulse, stall 4 cycles.
REQ-036 SH addr 0x202, wdata 0x1234_ABCD -> mem_we 1, be 1100, mem_wdata 0xABCD_ABCD, rdata_o 0.
REQ-037 LW addr 0x301 -> no mem_req_o, RESP next cycle, err_o 1, cause 01; func3 111 load -> cause 10.
REQ-038 TIMEOUT=4, no ack -> mem_req_o 4 cycles then low, err_o 1 cause 11; ack on 4th cycle -> no error.
REQ-039 rst_ni low during ACCESS -> mem_req_o 0 same cycle, no done_o; following LHU addr 0x2, rdata 0x8001_0000 -> rdata_o 0x0000_8001.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one datapath load/store request into a
// single word-aligned memory transaction with byte-lane enables, extends the
// returned load data, and reports misaligned, illegal-size and timeout faults.
module lsu_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        wren_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [1:0]  cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic        wren_q;
  logic [2:0]  func3_q;
  logic [1:0]  lane_q;
  logic [31:0] wait_q;
  logic        done_q;
  logic        err_q;

  logic        illegal_size;
  logic        misaligned;
  logic [3:0]  be_req;
  logic [31:0] wdata_req;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;
  logic        timeout_hit;

  // Decode the incoming request: fault checks, lane mask and replicated store data
  always_comb begin
    if (wren_i) illegal_size = !(func3_i inside {3'b000, 3'b001, 3'b010});
    else        illegal_size = func3_i inside {3'b011, 3'b110, 3'b111};
    misaligned = ((func3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((func3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    case (func3_i[1:0])
      2'b00:   be_req = 4'b0001 << addr_i[1:0];
      2'b01:   be_req = 4'b0011 << addr_i[1:0];
      default: be_req = 4'b1111;
    endcase
    case (func3_i[1:0])
      2'b00:   wdata_req = {4{wdata_i[7:0]}};
      2'b01:   wdata_req = {2{wdata_i[15:0]}};
      default: wdata_req = wdata_i;
    endcase
    if (!wren_i) wdata_req = 32'd0;
  end

  // Move the addressed lane down to bit 0 and sign/zero extend it
  always_comb begin
    rd_shifted = mem_rdata_i >> {lane_q, 3'b000};
    case (func3_q)
      3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_ext = {24'd0, rd_shifted[7:0]};
      3'b101:  load_ext = {16'd0, rd_shifted[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  // Wait limit reached on this ACCESS cycle (an ack in the same cycle still wins)
  assign timeout_hit = (TIMEOUT != 0) && ((wait_q + 32'd1) == 32'(TIMEOUT));

  // Freeze the datapath while a request is being accepted or is in flight
  assign stall_o = rst_ni & (((state_q == IDLE) & req_i) | (state_q == ACCESS));
  assign done_o  = done_q;
  assign err_o   = err_q;

  // Controller FSM with registered memory-side and response outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wren_q      <= 1'b0;
      func3_q     <= 3'd0;
      lane_q      <= 2'd0;
      wait_q      <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cause_o     <= 2'b00;
      rdata_o     <= 32'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_be_o    <= 4'd0;
      mem_wdata_o <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            if (illegal_size || misaligned) begin
              // Faulting request: skip memory, report straight away
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              cause_o <= illegal_size ? 2'b10 : 2'b01;
              rdata_o <= 32'd0;
            end else begin
              state_q     <= ACCESS;
              wren_q      <= wren_i;
              func3_q     <= func3_i;
              lane_q      <= addr_i[1:0];
              wait_q      <= 32'd0;
              mem_req_o   <= 1'b1;
              mem_we_o    <= wren_i;
              mem_addr_o  <= {addr_i[31:2], 2'b00};
              mem_be_o    <= be_req;
              mem_wdata_o <= wdata_req;
            end
          end
        end
        ACCESS: begin
          if (mem_ack_i || timeout_hit) begin
            state_q     <= RESP;
            done_q      <= 1'b1;
            err_q       <= !mem_ack_i;
            cause_o     <= mem_ack_i ? 2'b00 : 2'b11;
            rdata_o     <= (mem_ack_i && !wren_q) ? load_ext : 32'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        default: begin
          // RESP: single-cycle completion, incoming request ignored
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          cause_o <= 2'b00;
          rdata_o <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: each step drives one request, pushes its
// expected outcome into a scoreboard queue and compares on done_o.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        wren;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [1:0]  cause;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          stall_cycles;
    int          memreq_cycles;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wren_i(wren), .func3_i(func3),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done),
    .rdata_o(rdata), .err_o(err), .cause_o(cause), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic e_err, input logic [1:0] e_cause, input logic [31:0] e_rdata,
                      input logic e_we, input logic [3:0] e_be, input logic [31:0] e_maddr,
                      input logic [31:0] e_mwdata, input int e_stall, input int e_memreq);
    exp_t e;
    e.err = e_err; e.cause = e_cause; e.rdata = e_rdata; e.we = e_we; e.be = e_be;
    e.maddr = e_maddr; e.mwdata = e_mwdata; e.stall_cycles = e_stall; e.memreq_cycles = e_memreq;
    sb.push_back(e);
  endtask

  // ack_after: number of mem_req cycles to wait before acking; -1 = never ack
  task automatic run(input string name, input logic t_wren, input logic [2:0] t_f3,
                     input logic [31:0] t_addr, input logic [31:0] t_wdata,
                     input int ack_after, input logic [31:0] t_rdata);
    int stall_cnt = 0;
    int memreq_cnt = 0;
    bit got = 0;
    logic        c_we = 1'b0;
    logic [3:0]  c_be = 4'd0;
    logic [31:0] c_addr = 32'd0;
    logic [31:0] c_wd = 32'd0;
    exp_t e;
    @(negedge clk);
    req = 1'b1; wren = t_wren; func3 = t_f3; addr = t_addr; wdata = t_wdata;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (stall) stall_cnt++;
      if (mem_req) begin
        if (memreq_cnt == 0) begin
          c_we = mem_we; c_be = mem_be; c_addr = mem_addr; c_wd = mem_wdata;
        end else begin
          chk({name, " mem_addr_stable"}, mem_addr, c_addr);
        end
        mem_ack   = (ack_after >= 0) && (memreq_cnt == ack_after);
        mem_rdata = mem_ack ? t_rdata : 32'hA5A5_A5A5;
        memreq_cnt++;
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        got = 1;
        req = 1'b0;
        if (sb.size() == 0) begin
          checks++; failures++;
          $error("FAIL %s scoreboard_empty observed=done expected=none", name);
        end else begin
          e = sb.pop_front();
          chk({name, " err"}, 32'(err), 32'(e.err));
          chk({name, " cause"}, 32'(cause), 32'(e.cause));
          chk({name, " rdata"}, rdata, e.rdata);
          chk({name, " mem_we"}, 32'(c_we), 32'(e.we));
          chk({name, " mem_be"}, 32'(c_be), 32'(e.be));
          chk({name, " mem_addr"}, c_addr, e.maddr);
          chk({name, " mem_wdata"}, c_wd, e.mwdata);
          chk({name, " stall_cycles"}, 32'(stall_cnt), 32'(e.stall_cycles));
          chk({name, " memreq_cycles"}, 32'(memreq_cnt), 32'(e.memreq_cycles));
          chk({name, " stall_in_resp"}, 32'(stall), 32'd0);
        end
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++; failures++;
      $error("FAIL %s done_timeout observed=no_done expected=done", name);
      req = 1'b0;
    end else begin
      #1;
      chk({name, " done_one_pulse"}, 32'(done), 32'd0);
    end
    $display("txn %s stall=%0d memreq=%0d err=%0b cause=%0b rdata=%h",
             name, stall_cnt, memreq_cnt, err, cause, rdata);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; wren = 1'b0; func3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    rst_n = 1'b1;

    push(0, 2'b00, 32'hFFFF_FF80, 0, 4'b1000, 32'h100, 32'h0, 4, 3);
    run("LB_0x103", 0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF_FFFF);

    push(0, 2'b00, 32'h0, 1, 4'b1100, 32'h200, 32'hABCD_ABCD, 2, 1);
    run("SH_0x202", 1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 32'hFFFF_FFFF);

    push(1, 2'b01, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1, 0);
    run("LW_misaligned", 0, 3'b010, 32'h301, 32'h0, 0, 32'h0);

    push(1, 2'b10, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1, 0);
    run("LD_f3_111", 0, 3'b111, 32'h300, 32'h0, 0, 32'h0);

    push(1, 2'b11, 32'h0, 0, 4'b1111, 32'h400, 32'h0, 5, 4);
    run("LW_timeout", 0, 3'b010, 32'h400, 32'h0, -1, 32'h0);

    push(0, 2'b00, 32'hDEAD_BEEF, 0, 4'b1111, 32'h404, 32'h0, 5, 4);
    run("LW_ack_at_limit", 0, 3'b010, 32'h404, 32'h0, 3, 32'hDEAD_BEEF);

    push(0, 2'b00, 32'h0, 1, 4'b0010, 32'h10, 32'h5A5A_5A5A, 3, 2);
    run("SB_0x11", 1, 3'b000, 32'h11, 32'hFFFF_FF5A, 1, 32'h0);

    push(0, 2'b00, 32'hFFFF_8765, 0, 4'b1100, 32'h4, 32'h0, 2, 1);
    run("LH_0x6", 0, 3'b001, 32'h6, 32'h0, 0, 32'h8765_1234);

    push(0, 2'b00, 32'h0000_00F0, 0, 4'b0010, 32'h0, 32'h0, 2, 1);
    run("LBU_0x1", 0, 3'b100, 32'h1, 32'h0, 0, 32'h0000_F000);

    push(1, 2'b10, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1, 0);
    run("SHU_misaligned_illegal", 1, 3'b101, 32'h1, 32'h0, 0, 32'h0);

    push(1, 2'b01, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1, 0);
    run("SW_misaligned", 1, 3'b010, 32'h2, 32'h0, 0, 32'h0);

    // Reset in the middle of an access
    @(negedge clk);
    req = 1'b1; wren = 1'b0; func3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    #1;
    chk("rst_mid mem_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid stall", 32'(stall), 32'd0);
    req = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid no_done", 32'(done), 32'd0);
    end
    mem_ack = 1'b0;
    rst_n = 1'b1;
    $display("txn reset_during_access done=%0b mem_req=%0b", done, mem_req);

    push(0, 2'b00, 32'h0000_8001, 0, 4'b1100, 32'h0, 32'h0, 2, 1);
    run("LHU_after_reset", 0, 3'b101, 32'h2, 32'h0, 0, 32'h8001_0000);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
